// File: rtl/ip_pkg.sv
// Shared definitions for the IPv4 receive path: FSM states, header constants
// and the 16-bit ones'-complement adder used by the header checksum.
package ip_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHdr2,
    StHdr3,
    StHdr4,
    StHdr5,
    StOptions,
    StCheck,
    StPayload,
    StDrop,
    StDone
  } ip_state_e;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [3:0]  IP_MIN_IHL   = 4'd5;
  localparam logic [15:0] IP_HDR_BYTES = 16'd20;
  localparam logic [7:0]  PROTO_UDP    = 8'd17;
  localparam logic [7:0]  PROTO_TCP    = 8'd6;

  // 16-bit ones'-complement add with end-around carry. A second carry cannot
  // occur: the largest raw sum is 17'h1FFFE, which folds to 16'hFFFF.
  function automatic logic [15:0] one_complement_add(input logic [15:0] a,
                                                     input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Byte-keep mask for the final payload word; byte 0 sits in [31:24].
  function automatic logic [3:0] keep_mask(input logic [2:0] nbytes);
    logic [3:0] m;
    case (nbytes)
      3'd1:    m = 4'b1000;
      3'd2:    m = 4'b1100;
      3'd3:    m = 4'b1110;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones'-complement checksum accumulator over 32-bit words. Each accumulated
// word contributes its upper and lower halfwords. clear_i restarts the sum;
// clear_i together with acc_en_i starts a new sum with the current word.
module ip_csum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        acc_en_i,
  input  logic [31:0] word_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q, sum_d;
  logic [15:0] base;

  // Next sum: optionally restart from zero, then fold in both halfwords.
  always_comb begin
    base  = clear_i ? 16'h0000 : sum_q;
    sum_d = base;
    if (acc_en_i) begin
      sum_d = one_complement_add(one_complement_add(base, word_i[31:16]), word_i[15:0]);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 16'h0000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ip_rx_decoder.sv
// IPv4 receive decoder: captures header fields from a 32-bit big-endian word
// stream, validates checksum and sanity fields, then forwards the payload with
// a byte-keep mask on the last word, or silently drops it for a bad header.
module ip_rx_decoder
  import ip_pkg::*;
#(
  parameter int unsigned MAX_HDR_WORDS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pkt_data,
  input  logic        pkt_valid,
  output logic [3:0]  version,
  output logic [3:0]  ihl,
  output logic [7:0]  type_of_ser,
  output logic [15:0] total_len,
  output logic [15:0] identification,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [15:0] payload_len,
  output logic        hdr_valid,
  output logic        hdr_err,
  output logic [31:0] payload_data,
  output logic        payload_valid,
  output logic [3:0]  payload_keep,
  output logic        payload_last,
  output logic        fin
);

  ip_state_e   state_q, state_d;
  logic [3:0]  version_q, version_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  tos_q, tos_d;
  logic [15:0] total_len_q, total_len_d;
  logic [15:0] ident_q, ident_d;
  logic [2:0]  flag_q, flag_d;
  logic [12:0] frag_q, frag_d;
  logic [7:0]  ttl_q, ttl_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [3:0]  opt_left_q, opt_left_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [31:0] payload_data_q, payload_data_d;
  logic        payload_valid_q, payload_valid_d;
  logic [3:0]  payload_keep_q, payload_keep_d;
  logic        payload_last_q, payload_last_d;

  logic        csum_clear, csum_acc;
  logic [15:0] csum_sum;

  ip_csum_acc u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (csum_clear),
    .acc_en_i (csum_acc),
    .word_i   (pkt_data),
    .sum_o    (csum_sum)
  );

  logic [15:0] hdr_bytes;
  logic [15:0] rem_len;
  logic        len_ok, ihl_short, ihl_ok, hdr_good;

  // Header verdict, evaluated from the registered fields while in CHECK.
  always_comb begin
    hdr_bytes = {10'd0, ihl_q, 2'b00};
    rem_len   = total_len_q - hdr_bytes;
    len_ok    = (total_len_q >= hdr_bytes);
    ihl_short = (ihl_q < IP_MIN_IHL);
    ihl_ok    = !ihl_short && ({28'd0, ihl_q} <= MAX_HDR_WORDS);
    hdr_good  = (csum_sum == 16'hFFFF) && (version_q == IPV4_VERSION) && ihl_ok && len_ok;
  end

  logic        take_pl, take_drop;
  logic [15:0] bl;

  // Next-state, field capture and payload forwarding.
  always_comb begin
    state_d         = state_q;
    version_d       = version_q;
    ihl_d           = ihl_q;
    tos_d           = tos_q;
    total_len_d     = total_len_q;
    ident_d         = ident_q;
    flag_d          = flag_q;
    frag_d          = frag_q;
    ttl_d           = ttl_q;
    proto_d         = proto_q;
    src_d           = src_q;
    dst_d           = dst_q;
    opt_left_d      = opt_left_q;
    bytes_left_d    = bytes_left_q;
    payload_data_d  = payload_data_q;
    payload_valid_d = 1'b0;
    payload_keep_d  = 4'b0000;
    payload_last_d  = 1'b0;
    csum_clear      = 1'b0;
    csum_acc        = 1'b0;
    take_pl         = 1'b0;
    take_drop       = 1'b0;
    bl              = bytes_left_q;

    unique case (state_q)
      StIdle: begin
        csum_clear = 1'b1;
        if (pkt_valid) begin
          csum_acc    = 1'b1;
          version_d   = pkt_data[31:28];
          ihl_d       = pkt_data[27:24];
          tos_d       = pkt_data[23:16];
          total_len_d = pkt_data[15:0];
          state_d     = StHdr2;
        end
      end
      StHdr2: begin
        if (pkt_valid) begin
          csum_acc = 1'b1;
          ident_d  = pkt_data[31:16];
          flag_d   = pkt_data[15:13];
          frag_d   = pkt_data[12:0];
          state_d  = StHdr3;
        end
      end
      StHdr3: begin
        // The checksum halfword is summed but never stored.
        if (pkt_valid) begin
          csum_acc = 1'b1;
          ttl_d    = pkt_data[31:24];
          proto_d  = pkt_data[23:16];
          state_d  = StHdr4;
        end
      end
      StHdr4: begin
        if (pkt_valid) begin
          csum_acc = 1'b1;
          src_d    = pkt_data;
          state_d  = StHdr5;
        end
      end
      StHdr5: begin
        if (pkt_valid) begin
          csum_acc = 1'b1;
          dst_d    = pkt_data;
          if (ihl_q > IP_MIN_IHL) begin
            opt_left_d = ihl_q - IP_MIN_IHL;
            state_d    = StOptions;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StOptions: begin
        if (pkt_valid) begin
          csum_acc = 1'b1;
          if (opt_left_q == 4'd1) begin
            opt_left_d = 4'd0;
            state_d    = StCheck;
          end else begin
            opt_left_d = opt_left_q - 4'd1;
          end
        end
      end
      StCheck: begin
        // No input is waited for here, but a word that lands in this cycle
        // already belongs to the payload, so it is handled as such rather
        // than lost when the source streams back-to-back.
        if (hdr_good) begin
          if (rem_len == 16'd0) begin
            state_d = StDone;
          end else begin
            bl           = rem_len;
            bytes_left_d = rem_len;
            take_pl      = pkt_valid;
            state_d      = StPayload;
          end
        end else if (!len_ok || ihl_short || (rem_len == 16'd0)) begin
          state_d = StDone;
        end else begin
          bl           = rem_len;
          bytes_left_d = rem_len;
          take_drop    = pkt_valid;
          state_d      = StDrop;
        end
      end
      StPayload: take_pl   = pkt_valid;
      StDrop:    take_drop = pkt_valid;
      StDone:    state_d   = StIdle;
      default:   state_d   = StIdle;
    endcase

    if (take_pl) begin
      payload_data_d  = pkt_data;
      payload_valid_d = 1'b1;
      if (bl <= 16'd4) begin
        payload_last_d = 1'b1;
        payload_keep_d = keep_mask(bl[2:0]);
        bytes_left_d   = 16'd0;
        state_d        = StDone;
      end else begin
        payload_keep_d = 4'b1111;
        bytes_left_d   = bl - 16'd4;
      end
    end

    if (take_drop) begin
      if (bl <= 16'd4) begin
        bytes_left_d = 16'd0;
        state_d      = StDone;
      end else begin
        bytes_left_d = bl - 16'd4;
      end
    end
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      version_q       <= '0;
      ihl_q           <= '0;
      tos_q           <= '0;
      total_len_q     <= '0;
      ident_q         <= '0;
      flag_q          <= '0;
      frag_q          <= '0;
      ttl_q           <= '0;
      proto_q         <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      opt_left_q      <= '0;
      bytes_left_q    <= '0;
      payload_data_q  <= '0;
      payload_valid_q <= 1'b0;
      payload_keep_q  <= '0;
      payload_last_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      version_q       <= version_d;
      ihl_q           <= ihl_d;
      tos_q           <= tos_d;
      total_len_q     <= total_len_d;
      ident_q         <= ident_d;
      flag_q          <= flag_d;
      frag_q          <= frag_d;
      ttl_q           <= ttl_d;
      proto_q         <= proto_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      opt_left_q      <= opt_left_d;
      bytes_left_q    <= bytes_left_d;
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      payload_keep_q  <= payload_keep_d;
      payload_last_q  <= payload_last_d;
    end
  end

  assign version        = version_q;
  assign ihl            = ihl_q;
  assign type_of_ser    = tos_q;
  assign total_len      = total_len_q;
  assign identification = ident_q;
  assign flag           = flag_q;
  assign frag_offset    = frag_q;
  assign time_to_live   = ttl_q;
  assign protocol       = proto_q;
  assign src_ip         = src_q;
  assign dest_ip        = dst_q;
  assign payload_len    = rem_len;
  assign hdr_valid      = (state_q == StCheck) && hdr_good;
  assign hdr_err        = (state_q == StCheck) && !hdr_good;
  assign fin            = (state_q == StDone);
  assign payload_data   = payload_data_q;
  assign payload_valid  = payload_valid_q;
  assign payload_keep   = payload_keep_q;
  assign payload_last   = payload_last_q;

endmodule

// File: tb/tb_ip_rx_decoder.sv
// Directed bench for ip_rx_decoder: hand-built IPv4 packets with precomputed
// checksums; a negedge monitor logs pulses and payload words for checking.
module tb_ip_rx_decoder;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [31:0] pkt_data  = 32'h0;
  logic        pkt_valid = 1'b0;

  logic [3:0]  version, ihl;
  logic [7:0]  type_of_ser, time_to_live, protocol;
  logic [15:0] total_len, identification, payload_len;
  logic [2:0]  flag;
  logic [12:0] frag_offset;
  logic [31:0] src_ip, dest_ip, payload_data;
  logic        hdr_valid, hdr_err, payload_valid, payload_last, fin;
  logic [3:0]  payload_keep;

  ip_rx_decoder #(.MAX_HDR_WORDS(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .version        (version),
    .ihl            (ihl),
    .type_of_ser    (type_of_ser),
    .total_len      (total_len),
    .identification (identification),
    .flag           (flag),
    .frag_offset    (frag_offset),
    .time_to_live   (time_to_live),
    .protocol       (protocol),
    .src_ip         (src_ip),
    .dest_ip        (dest_ip),
    .payload_len    (payload_len),
    .hdr_valid      (hdr_valid),
    .hdr_err        (hdr_err),
    .payload_data   (payload_data),
    .payload_valid  (payload_valid),
    .payload_keep   (payload_keep),
    .payload_last   (payload_last),
    .fin            (fin)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Event log sampled away from the active edge.
  int unsigned cyc = 0, n_hv = 0, n_he = 0, n_fin = 0, n_pl = 0, fin_cyc = 0, last_cyc = 0;
  logic [31:0] pl_data [64];
  logic [3:0]  pl_keep [64];
  logic        pl_last [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (hdr_valid) n_hv <= n_hv + 1;
    if (hdr_err) n_he <= n_he + 1;
    if (fin) begin
      n_fin   <= n_fin + 1;
      fin_cyc <= cyc;
    end
    if (payload_valid) begin
      pl_data[n_pl[5:0]] <= payload_data;
      pl_keep[n_pl[5:0]] <= payload_keep;
      pl_last[n_pl[5:0]] <= payload_last;
      if (payload_last) last_cyc <= cyc;
      n_pl <= n_pl + 1;
    end
  end

  logic [31:0] pw [16];
  int          pn;
  int unsigned b_hv, b_he, b_fin, b_pl;

  task automatic snap();
    b_hv  = n_hv;
    b_he  = n_he;
    b_fin = n_fin;
    b_pl  = n_pl;
  endtask

  task automatic send_pkt(input int gap);
    for (int i = 0; i < pn; i++) begin
      @(negedge clk);
      pkt_data  = pw[i];
      pkt_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_data  = 32'hFFFF_FFFF;
      end
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    pkt_data  = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int unsigned hv, input int unsigned he,
                              input int unsigned fn, input int unsigned pl);
    check_eq({tag, ".hdr_valid_cnt"}, n_hv - b_hv, hv);
    check_eq({tag, ".hdr_err_cnt"}, n_he - b_he, he);
    check_eq({tag, ".fin_cnt"}, n_fin - b_fin, fn);
    check_eq({tag, ".payload_cnt"}, n_pl - b_pl, pl);
  endtask

  task automatic check_pl(input string tag, input int unsigned k, input logic [31:0] d,
                          input logic [3:0] keep, input logic last);
    logic [5:0] idx;
    idx = 6'(b_pl + k);
    check_eq({tag, ".data"}, pl_data[idx], d);
    check_eq({tag, ".keep"}, {28'd0, pl_keep[idx]}, {28'd0, keep});
    check_eq({tag, ".last"}, {31'd0, pl_last[idx]}, {31'd0, last});
  endtask

  // Packet 1: UDP, ihl=5, total_len=28, checksum 0xA684, 8 payload bytes.
  task automatic load_pkt1();
    pw[0] = 32'h4500_001C;
    pw[1] = 32'h1234_4000;
    pw[2] = 32'h4011_A684;
    pw[3] = 32'hC0A8_0001;
    pw[4] = 32'hC0A8_00C7;
    pw[5] = 32'hDEAD_BEEF;
    pw[6] = 32'h0123_4567;
    pn    = 7;
  endtask

  task automatic check_pkt1(input string tag);
    check_counts(tag, 1, 0, 1, 2);
    check_eq({tag, ".version"}, {28'd0, version}, 32'd4);
    check_eq({tag, ".ihl"}, {28'd0, ihl}, 32'd5);
    check_eq({tag, ".tos"}, {24'd0, type_of_ser}, 32'd0);
    check_eq({tag, ".total_len"}, {16'd0, total_len}, 32'd28);
    check_eq({tag, ".ident"}, {16'd0, identification}, 32'h1234);
    check_eq({tag, ".flag"}, {29'd0, flag}, 32'd2);
    check_eq({tag, ".frag"}, {19'd0, frag_offset}, 32'd0);
    check_eq({tag, ".ttl"}, {24'd0, time_to_live}, 32'h40);
    check_eq({tag, ".protocol"}, {24'd0, protocol}, 32'd17);
    check_eq({tag, ".src_ip"}, src_ip, 32'hC0A8_0001);
    check_eq({tag, ".dest_ip"}, dest_ip, 32'hC0A8_00C7);
    check_eq({tag, ".payload_len"}, {16'd0, payload_len}, 32'd8);
    check_pl({tag, ".pl0"}, 0, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    check_pl({tag, ".pl1"}, 1, 32'h0123_4567, 4'b1111, 1'b1);
    check_eq({tag, ".fin_with_last"}, fin_cyc, last_cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".version"}, {28'd0, version}, 32'd0);
    check_eq({tag, ".total_len"}, {16'd0, total_len}, 32'd0);
    check_eq({tag, ".src_ip"}, src_ip, 32'd0);
    check_eq({tag, ".dest_ip"}, dest_ip, 32'd0);
    check_eq({tag, ".protocol"}, {24'd0, protocol}, 32'd0);
    check_eq({tag, ".payload_len"}, {16'd0, payload_len}, 32'd0);
    check_eq({tag, ".payload_data"}, payload_data, 32'd0);
    check_eq({tag, ".pulses"}, {27'd0, hdr_valid, hdr_err, payload_valid, payload_last, fin},
             32'd0);
    check_eq({tag, ".keep"}, {28'd0, payload_keep}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: back-to-back UDP packet.
    load_pkt1();
    snap();
    send_pkt(0);
    check_pkt1("t1");

    // 2: 3-byte payload, one word with keep 1110.
    load_pkt1();
    pw[0] = 32'h4500_0017;
    pw[2] = 32'h4011_A689;
    pw[5] = 32'hAABB_CCDD;
    pn    = 6;
    snap();
    send_pkt(0);
    check_counts("t2", 1, 0, 1, 1);
    check_eq("t2.payload_len", {16'd0, payload_len}, 32'd3);
    check_pl("t2.pl0", 0, 32'hAABB_CCDD, 4'b1110, 1'b1);

    // 3: ihl=6 with one option word, TCP, total_len=32.
    load_pkt1();
    pw[0] = 32'h4600_0020;
    pw[2] = 32'h4006_A389;
    pw[5] = 32'h0101_0101;
    pw[6] = 32'h1111_2222;
    pw[7] = 32'h3333_4444;
    pn    = 8;
    snap();
    send_pkt(0);
    check_counts("t3", 1, 0, 1, 2);
    check_eq("t3.ihl", {28'd0, ihl}, 32'd6);
    check_eq("t3.protocol", {24'd0, protocol}, 32'd6);
    check_eq("t3.payload_len", {16'd0, payload_len}, 32'd8);
    check_pl("t3.pl0", 0, 32'h1111_2222, 4'b1111, 1'b0);
    check_pl("t3.pl1", 1, 32'h3333_4444, 4'b1111, 1'b1);

    // 4: checksum off by one; payload dropped, single fin.
    load_pkt1();
    pw[2] = 32'h4011_A685;
    snap();
    send_pkt(0);
    check_counts("t4", 0, 1, 1, 0);

    // 4b: version 6 with an otherwise consistent checksum is also rejected.
    load_pkt1();
    pw[0] = 32'h6500_001C;
    pw[2] = 32'h4011_8684;
    snap();
    send_pkt(0);
    check_counts("t4b", 0, 1, 1, 0);

    // 5: same as packet 1 with a one-cycle gap after every word.
    load_pkt1();
    snap();
    send_pkt(1);
    check_pkt1("t5");

    // 6: reset while the first payload word is presented.
    load_pkt1();
    snap();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pkt_data  = pw[i];
      pkt_valid = 1'b1;
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    @(negedge clk);
    pkt_data  = pw[5];
    pkt_valid = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check_all_zero("t6.after_reset");
    reset     = 1'b0;
    pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_counts("t6.abort", 1, 0, 0, 0);

    load_pkt1();
    snap();
    send_pkt(0);
    check_pkt1("t6.next");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
